booth2_encoder: RTL
===================

# booth2_encoder

Sequential radix-4 Booth encoder for the iterative multiplier in the EXU. It captures a multiplier operand, extends it by sign or zero, and emits one 3-bit Booth digit per cycle to the partial-product stage over a valid/ready handshake. The partial-product stage decodes each digit against the multiplicand. Optional early termination stops the digit stream once all remaining digits would select a zero partial product.

## Interface
- `WIDTH`, default 64: multiplier operand width. Must be even.
- `EARLY_TERM`, default 1: when 1, enables early termination of the digit stream.
- `NDIG` (local), value WIDTH/2+1: maximum number of digits. Equals 33 at the default width.
- `clock`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high.
- `flush`  in  1: pipeline cancel. Aborts any operation in progress.
- `mul_valid`  in  1: operand offered.
- `mul_ready`  out  1: encoder can accept an operand.
- `mul_y`  in  WIDTH: multiplier operand.
- `mul_signed`  in  1: 1 selects sign extension of `mul_y`; 0 selects zero extension.
- `code_valid`  out  1: a digit is presented.
- `code_ready`  in  1: consumer accepts the digit.
- `code`  out  3: Booth digit {y[2i+1], y[2i], y[2i-1]}.
- `code_idx`  out  $clog2(NDIG): digit index i. The partial product is shifted left by 2i.
- `code_last`  out  1: this is the final digit of the operation.

## Operation
- The extended operand `ye` is WIDTH+2 bits: `mul_y` extended by sign or zero per `mul_signed`.
- Shift register `sr` is WIDTH+3 bits. It loads as {ye, 1'b0}, where bit 0 is y[-1]=0.
- `code` = sr[2:0].
- On each accepted digit, `sr` shifts right arithmetically by 2, replicating the MSB.
- FSM state IDLE:
  - `mul_ready`=1, `code_valid`=0.
  - `mul_valid`&`mul_ready` loads `sr`, clears `idx`, and moves to RUN.
- FSM state RUN:
  - `mul_ready`=0, `code_valid`=1.
  - `code_valid`&`code_ready` advances `sr` and increments `idx`.
  - If the accepted digit has `code_last`=1, the FSM returns to IDLE instead.
- `code_last` = (idx == NDIG-1) | (EARLY_TERM & all bits sr[WIDTH+2:2] equal).
  - When all those bits are equal, every later digit is 000 or 111, i.e. a zero partial product.
- Digit 0 is always emitted, including for a zero operand. For a zero operand, digit 0 is 000 with `code_last`=1.
- `flush` has the highest priority:
  - Next state is IDLE in any state.
  - Any digit presented in that cycle is considered not transferred.
  - A `mul_valid` in the same cycle is ignored.
- `reset` returns the FSM to IDLE and clears `sr`, `idx`, `code_valid` and `code_last`. The reset value of `mul_ready` is 1.
- `reset` in the middle of an operation behaves like `flush`.

## Timing
- Operand accepted at edge T → first digit valid from T+1.
- Throughput: one digit per cycle while `code_ready`=1.
- When `code_ready`=0, `code`, `code_idx` and `code_last` are held stable and `code_valid` stays high.
- Last digit accepted at edge T → IDLE at T+1 → `mul_ready`=1 at T+1. The earliest next load is at T+1, which gives a 1-cycle bubble between operations.
- Worst-case latency is NDIG digits, i.e. 33 cycles at WIDTH=64 with no backpressure.
- All outputs are registered or decoded from state only. There is no combinational path from `mul_*` to `code_*`.

## Structure
- Shared package holds:
  - FSM state typedef (IDLE, RUN).
  - Booth code constants: B_ZERO0=000, B_P1A=001, B_P1B=010, B_P2=011, B_M2=100, B_M1A=101, B_M1B=110, B_ZERO1=111. These are shared with the partial-product decode.
  - `NDIG` width helper.
- One sub-module: `booth2_uniform_detect`. It is a combinational all-bits-equal reduction over a parameterized width and drives early termination.

## Test plan
- WIDTH=64, EARLY_TERM=1, `mul_y`=3, unsigned → digits idx0=110, idx1=001 with `code_last`. Weighted sum 3.
- `mul_y`=all ones, signed → single digit idx0=110 with `code_last` (value -1).
- `mul_y`=0x8000_0000_0000_0000:
  - Unsigned → idx0..30=000, idx31=100, idx32=001 with `code_last` (value 2^63).
  - Signed → `code_last` at idx31=100 (value -2^63).
- EARLY_TERM=0, `mul_y`=0 → 33 digits of 000. `code_last` only at idx32. `mul_ready` returns the cycle after.
- Random `code_ready` stalls → `code`, `code_idx` and `code_last` are held while stalled. Reconstructed Σ d_i·4^i equals `mul_y` interpreted per `mul_signed` across 1000 random operands.
- `flush` asserted at idx5 (and `reset` at idx10 in a second run) → `code_valid`=0 the next cycle and `mul_ready`=1. A new operand then starts at idx0.

Source files
------------

// File: rtl/booth2_encoder_pkg.sv
// Shared types and constants for the radix-4 Booth encoder and the partial-product decode.
package booth2_encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Digit encodings {y[2i+1], y[2i], y[2i-1]}; the decode side selects 0, +/-X or +/-2X
  localparam logic [2:0] B_ZERO0 = 3'b000;
  localparam logic [2:0] B_P1A   = 3'b001;
  localparam logic [2:0] B_P1B   = 3'b010;
  localparam logic [2:0] B_P2    = 3'b011;
  localparam logic [2:0] B_M2    = 3'b100;
  localparam logic [2:0] B_M1A   = 3'b101;
  localparam logic [2:0] B_M1B   = 3'b110;
  localparam logic [2:0] B_ZERO1 = 3'b111;

  function automatic int ndig_of(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int idx_w(input int width);
    return (ndig_of(width) <= 2) ? 1 : $clog2(ndig_of(width));
  endfunction

endpackage

// File: rtl/booth2_uniform_detect.sv
// All-bits-equal reduction; high when every bit of the vector is 0 or every bit is 1.
module booth2_uniform_detect #(
  parameter int W = 65
) (
  input  logic [W-1:0] i_bits,
  output logic         o_uniform
);

  assign o_uniform = (&i_bits) | (~|i_bits);

endmodule

// File: rtl/booth2_encoder.sv
// Sequential radix-4 Booth encoder: captures a multiplier operand and streams one
// Booth digit per accepted handshake, optionally stopping once the rest would all be zero.
//
//   state | meaning
//   IDLE  | waiting for an operand, mul_ready high
//   RUN   | presenting digit code_idx, code_valid high
module booth2_encoder
  import booth2_encoder_pkg::*;
#(
  parameter  int WIDTH      = 64,
  parameter  int EARLY_TERM = 1,
  localparam int NDIG       = ndig_of(WIDTH),
  localparam int IDXW       = idx_w(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             mul_valid,
  output logic             mul_ready,
  input  logic [WIDTH-1:0] mul_y,
  input  logic             mul_signed,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [2:0]       code,
  output logic [IDXW-1:0]  code_idx,
  output logic             code_last
);

  localparam int SRW = WIDTH + 3;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SRW-1:0]   r_sr;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH+1:0] w_ye;
  logic             w_uniform;
  logic             w_load;
  logic             w_accept;

  assign w_ye = mul_signed ? {{2{mul_y[WIDTH-1]}}, mul_y} : {2'b00, mul_y};

  // Once sr[MSB:2] is uniform, every later digit is 000 or 111
  booth2_uniform_detect #(
    .W (WIDTH + 1)
  ) u_uniform (
    .i_bits    (r_sr[SRW-1:2]),
    .o_uniform (w_uniform)
  );

  assign w_load   = mul_valid & mul_ready & ~flush;
  assign w_accept = code_valid & code_ready & ~flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_load) w_state_nxt = RUN;
        RUN:     if (w_accept && code_last) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    mul_ready  = (r_state == IDLE);
    code_valid = (r_state == RUN);
    code_last  = code_valid &
                 ((r_idx == LAST_IDX) | ((EARLY_TERM != 0) & w_uniform));
  end

  assign code     = r_sr[2:0];
  assign code_idx = r_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sr  <= '0;
      r_idx <= '0;
    end else if (w_load) begin
      r_sr  <= {w_ye, 1'b0};
      r_idx <= '0;
    end else if (w_accept) begin
      r_sr  <= {{2{r_sr[SRW-1]}}, r_sr[SRW-1:2]};
      r_idx <= r_idx + IDXW'(1);
    end
  end

endmodule
